hydra_join_scheduler: RTL

Parametrised join scheduler between the SRAM write interfaces and the per-port output queues. It accepts "packet complete" join requests from every SRAM and services them strictly in arrival-batch order, one per cycle, then appends each packet to its destination port's priority queue. Appending to a non-empty queue emits a valid/ready concatenation command (previous tail, new head) to the owning SRAM, and the read side pops queue heads through a dequeue port. This block generalises the fixed 32-SRAM/16-port/8-priority join logic, adds lossless back-pressure on both sides, and adds a dequeue path.

---
 rtl/hydra_join_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hydra_join_scheduler.sv
// Join scheduler: batches SRAM "packet complete" requests, appends them to per-port
// priority queues and emits tail->head link commands. JOIN_SCHED_RR_EN selects round-robin.
module hydra_join_scheduler #(
  parameter int NUM_SRAM    = 32,
  parameter int NUM_PORT    = 16,
  parameter int NUM_PRIOR   = 8,
  parameter int ADDR_W      = 16,
  parameter int BATCH_DEPTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_SRAM-1:0]                    join_req,
  input  logic [NUM_SRAM*$clog2(NUM_PORT)-1:0]   join_port,
  input  logic [NUM_SRAM*$clog2(NUM_PRIOR)-1:0]  join_prior,
  input  logic [NUM_SRAM*ADDR_W-1:0]             join_head,
  input  logic [NUM_SRAM*ADDR_W-1:0]             join_tail,
  output logic [NUM_SRAM-1:0]                    join_ack,
  output logic                                   cat_vld,
  input  logic                                   cat_ready,
  output logic [ADDR_W-1:0]                      cat_prev,
  output logic [ADDR_W-1:0]                      cat_next,
  output logic [$clog2(NUM_SRAM)-1:0]            cat_sram,
  input  logic                                   deq_vld,
  input  logic [$clog2(NUM_PORT)-1:0]            deq_port,
  input  logic [$clog2(NUM_PRIOR)-1:0]           deq_prior,
  input  logic [ADDR_W-1:0]                      deq_next,
  input  logic                                   deq_last,
  input  logic [$clog2(NUM_PORT)-1:0]            rd_port,
  input  logic [$clog2(NUM_PRIOR)-1:0]           rd_prior,
  output logic [ADDR_W-1:0]                      rd_head,
  output logic [NUM_PORT*NUM_PRIOR-1:0]          q_empty,
  output logic                                   batch_full
);
  localparam int SRAM_W  = $clog2(NUM_SRAM);
  localparam int PORT_W  = $clog2(NUM_PORT);
  localparam int PRIOR_W = $clog2(NUM_PRIOR);
  localparam int NUM_Q   = NUM_PORT * NUM_PRIOR;
  localparam int Q_W     = $clog2(NUM_Q);
  localparam int PTR_W   = $clog2(BATCH_DEPTH);

  logic [NUM_SRAM-1:0] pending, arrivals, cur_set, rest_set, sel_onehot;
  logic [NUM_SRAM-1:0] fifo_mem [BATCH_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full, push, svc, join_new;
  logic [SRAM_W-1:0]   sel;
  logic [PORT_W-1:0]   sel_port;
  logic [PRIOR_W-1:0]  sel_prior;
  logic [ADDR_W-1:0]   sel_head, sel_tail;
  logic [Q_W-1:0]      sel_q, deq_q, rd_q;
  logic [ADDR_W-1:0]   head_q [NUM_Q];
  logic [ADDR_W-1:0]   tail_q [NUM_Q];
  logic [NUM_Q-1:0]    empty_q;
  int unsigned         idx;

  function automatic logic [Q_W-1:0] qidx(input logic [PORT_W-1:0] p,
                                          input logic [PRIOR_W-1:0] r);
    return Q_W'(32'(p) * NUM_PRIOR + 32'(r));
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // The ack pulse masks the request the SRAM is still holding while it sees the ack.
  assign arrivals   = join_req & ~pending & ~join_ack;
  assign push       = (arrivals != '0) && !fifo_full;
  assign cur_set    = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign svc        = (cur_set != '0) && !(cat_vld && !cat_ready);
  assign sel_onehot = svc ? (NUM_SRAM'(1) << sel) : '0;
  assign rest_set   = cur_set & ~sel_onehot;

`ifdef JOIN_SCHED_RR_EN
  logic [SRAM_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)      rr_ptr <= '0;
    else if (svc) rr_ptr <= SRAM_W'((32'(sel) + 1) % NUM_SRAM);
  end
`endif

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int unsigned k = 0; k < NUM_SRAM; k++) begin
`ifdef JOIN_SCHED_RR_EN
      idx = (32'(rr_ptr) + NUM_SRAM - 1 - k) % NUM_SRAM;
`else
      idx = NUM_SRAM - 1 - k;
`endif
      if (cur_set[idx]) sel = SRAM_W'(idx);
    end
  end

  always_comb begin
    sel_port  = join_port[32'(sel)*PORT_W +: PORT_W];
    sel_prior = join_prior[32'(sel)*PRIOR_W +: PRIOR_W];
    sel_head  = join_head[32'(sel)*ADDR_W +: ADDR_W];
    sel_tail  = join_tail[32'(sel)*ADDR_W +: ADDR_W];
    sel_q     = qidx(sel_port, sel_prior);
    deq_q     = qidx(deq_port, deq_prior);
    rd_q      = qidx(rd_port, rd_prior);
    join_new  = empty_q[sel_q] || (deq_vld && deq_last && (deq_q == sel_q));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= arrivals;
      if (svc && rest_set != '0) fifo_mem[rd_ptr[PTR_W-1:0]] <= rest_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      join_ack <= '0;
      cat_vld  <= 1'b0;
      cat_prev <= '0;
      cat_next <= '0;
      empty_q  <= '1;
      for (int unsigned q = 0; q < NUM_Q; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
      end
    end else begin
      pending  <= (pending | (push ? arrivals : '0)) & ~sel_onehot;
      join_ack <= sel_onehot;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (cat_vld && cat_ready) cat_vld <= 1'b0;
      if (deq_vld && !empty_q[deq_q]) begin
        if (deq_last) empty_q[deq_q] <= 1'b1;
        else          head_q[deq_q]  <= deq_next;
      end
      // Join updates come last so they override a same-queue dequeue.
      if (svc) begin
        if (rest_set == '0) rd_ptr <= rd_ptr + 1'b1;
        tail_q[sel_q] <= sel_tail;
        if (join_new) begin
          head_q[sel_q]  <= sel_head;
          empty_q[sel_q] <= 1'b0;
        end else begin
          cat_vld  <= 1'b1;
          cat_prev <= tail_q[sel_q];
          cat_next <= sel_head;
        end
      end
    end
  end

  assign cat_sram   = cat_prev[ADDR_W-1 -: SRAM_W];
  assign rd_head    = head_q[rd_q];
  assign q_empty    = empty_q;
  assign batch_full = fifo_full;

endmodule
